// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one producer at a time a burst of up to
// BURST words into a shared FIFO write port, never writing while the FIFO is full.
module fifo_wr_arb #(
  parameter int WIDTH = 24,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] din,
  output logic [N-1:0]       ack,
  output logic [N-1:0]       gnt,
  output logic               fifo_wr,
  output logic [WIDTH-1:0]   fifo_din,
  input  logic               fifo_full
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t            state, stateNext;
  logic [N-1:0]      gntNext;
  logic [IW-1:0]     ptr, ptrNext;
  logic [IW-1:0]     own, ownNext, ownInc;
  logic [CW-1:0]     cnt, cntNext;
  logic [WIDTH-1:0]  lastDin;
  logic [WIDTH-1:0]  ownWord;
  logic [IW-1:0]     cand;
  logic [IW-1:0]     pick;
  logic              pickValid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      own     <= '0;
      lastDin <= '0;
    end else begin
      state   <= stateNext;
      gnt     <= gntNext;
      ptr     <= ptrNext;
      cnt     <= cntNext;
      own     <= ownNext;
      lastDin <= fifo_din;
    end
  end

  // First requester at or after ptr, wrapping modulo N.
  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!pickValid && req[cand]) begin
        pickValid = 1'b1;
        pick      = cand;
      end
    end
  end

  always_comb begin
    ownWord = '0;
    for (int i = 0; i < N; i++) begin
      if (own == IW'(i)) ownWord = din[i*WIDTH +: WIDTH];
    end
  end

  assign ownInc = (own == IW'(N - 1)) ? '0 : own + 1'b1;

  // lastDin keeps fifo_din steady between bursts; it is zero out of reset.
  always_comb begin
    stateNext = state;
    gntNext   = gnt;
    ptrNext   = ptr;
    cntNext   = cnt;
    ownNext   = own;
    fifo_wr   = 1'b0;
    ack       = '0;
    fifo_din  = lastDin;
    case (state)
      ST_IDLE: begin
        if (pickValid) begin
          gntNext   = {{(N-1){1'b0}}, 1'b1} << pick;
          ownNext   = pick;
          cntNext   = '0;
          stateNext = ST_BURST;
        end
      end
      ST_BURST: begin
        fifo_din = ownWord;
        fifo_wr  = req[own] & ~fifo_full;
        ack      = fifo_wr ? gnt : '0;
        if (fifo_wr) cntNext = cnt + 1'b1;
        if (!req[own] || (fifo_wr && cnt == CW'(BURST - 1))) begin
          stateNext = ST_IDLE;
          gntNext   = '0;
          ptrNext   = ownInc;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-cycle vector table plus hand sequences
// for round-robin rotation and asynchronous reset during a burst.
module tb_fifo_wr_arb;

  localparam int W = 24;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [23:0]      d0, d1, d2, d3;
  logic [N*W-1:0]   din;
  logic [N-1:0]     ack;
  logic [N-1:0]     gnt;
  logic             fifo_wr;
  logic [W-1:0]     fifo_din;
  logic             fifo_full;

  int total = 0;
  int bad   = 0;
  logic [23:0] logQ[$];

  typedef struct {
    logic        rstBefore;
    logic [3:0]  req;
    logic        full;
    logic [23:0] d0, d1, d2, d3;
    logic        expWr;
    logic [3:0]  expGnt;
    logic [23:0] expDin;
  } vec_t;

  vec_t vecs[$];

  assign din = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  fifo_wr_arb #(.WIDTH(W), .N(N), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .gnt(gnt),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full)
  );

  // Every word the arbiter pushes into the FIFO, in order.
  always @(posedge clk) begin
    if (fifo_wr) logQ.push_back(fifo_din);
  end

  function automatic vec_t mk(input logic rb, input logic [3:0] r, input logic f,
                              input logic [23:0] a0, input logic [23:0] a1,
                              input logic [23:0] a2, input logic [23:0] a3,
                              input logic ew, input logic [3:0] eg, input logic [23:0] ed);
    vec_t v;
    v.rstBefore = rb; v.req = r; v.full = f;
    v.d0 = a0; v.d1 = a1; v.d2 = a2; v.d3 = a3;
    v.expWr = ew; v.expGnt = eg; v.expDin = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic resetPulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    logQ.delete();
  endtask

  int ack2Count;

  task automatic applyStimulus(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vecs[i].rstBefore) resetPulse();
      req = vecs[i].req; fifo_full = vecs[i].full;
      d0 = vecs[i].d0; d1 = vecs[i].d1; d2 = vecs[i].d2; d3 = vecs[i].d3;
      #2;
      if (ack[2]) ack2Count++;
      checkOutput($sformatf("row%0d wr", i), 32'(fifo_wr), 32'(vecs[i].expWr));
      checkOutput($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].expGnt));
      checkOutput($sformatf("row%0d ack", i), 32'(ack), vecs[i].expWr ? 32'(vecs[i].expGnt) : 32'd0);
      if (vecs[i].expWr) checkOutput($sformatf("row%0d din", i), 32'(fifo_din), 32'(vecs[i].expDin));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int k[4];
    int cyc;
    int hits;
    logic [3:0] prevGnt;
    logic [3:0] gseq[$];

    rst = 1'b1; req = '0; fifo_full = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    ack2Count = 0;

    // single producer 2, two bursts (rows 0..9)
    vecs.push_back(mk(1, 4'b0100, 0, 0, 0, 24'h10, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h10, 0, 1, 4'b0100, 24'h10));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h11, 0, 1, 4'b0100, 24'h11));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h12, 0, 1, 4'b0100, 24'h12));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h13, 0, 1, 4'b0100, 24'h13));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h14, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h14, 0, 1, 4'b0100, 24'h14));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 0, 24'h15, 0, 1, 4'b0100, 24'h15));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 24'h15, 0, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 24'h15, 0, 0, 4'b0000, 0));
    // full stall on producer 1 (rows 10..16)
    vecs.push_back(mk(1, 4'b0010, 1, 0, 24'h555555, 0, 0, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 24'h555555, 0, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 24'h555555, 0, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, 24'h555555, 0, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 24'h555555, 0, 0, 1, 4'b0010, 24'h555555));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 24'h555555, 0, 0, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 24'h555555, 0, 0, 0, 4'b0000, 0));
    // owner 1 drops after 2 words, pending 3 wins over re-asserted 1 (rows 17..25)
    vecs.push_back(mk(1, 4'b0010, 0, 0, 24'h100, 0, 24'h300, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 24'h100, 0, 24'h300, 1, 4'b0010, 24'h100));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 24'h101, 0, 24'h300, 1, 4'b0010, 24'h101));
    vecs.push_back(mk(0, 4'b1000, 0, 0, 24'h102, 0, 24'h300, 0, 4'b0010, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 24'h102, 0, 24'h300, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1010, 0, 0, 24'h102, 0, 24'h300, 1, 4'b1000, 24'h300));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 24'h102, 0, 24'h301, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 24'h102, 0, 24'h301, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0010, 0, 0, 24'h102, 0, 24'h301, 1, 4'b0010, 24'h102));
    // pointer wrap from 3 to 0 (rows 26..33)
    vecs.push_back(mk(1, 4'b0100, 0, 24'h0aa, 0, 24'h200, 24'h333, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 24'h0aa, 0, 24'h200, 24'h333, 1, 4'b0100, 24'h200));
    vecs.push_back(mk(0, 4'b1001, 0, 24'h0aa, 0, 24'h201, 24'h333, 0, 4'b0100, 0));
    vecs.push_back(mk(0, 4'b1001, 0, 24'h0aa, 0, 24'h201, 24'h333, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b1001, 0, 24'h0aa, 0, 24'h201, 24'h333, 1, 4'b1000, 24'h333));
    vecs.push_back(mk(0, 4'b0001, 0, 24'h0aa, 0, 24'h201, 24'h334, 0, 4'b1000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 24'h0aa, 0, 24'h201, 24'h334, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 24'h0aa, 0, 24'h201, 24'h334, 1, 4'b0001, 24'h0aa));

    #2;
    checkOutput("reset gnt", 32'(gnt), 0);
    checkOutput("reset wr", 32'(fifo_wr), 0);
    checkOutput("reset ack", 32'(ack), 0);
    checkOutput("reset din", 32'(fifo_din), 0);
    @(posedge clk); #1;

    applyStimulus(0, 9);
    checkOutput("single ack2 pulses", 32'(ack2Count), 6);
    checkOutput("single log size", 32'(logQ.size()), 6);
    for (int j = 0; j < 6 && j < logQ.size(); j++)
      checkOutput($sformatf("single log%0d", j), 32'(logQ[j]), 32'h10 + 32'(j));

    applyStimulus(10, 16);
    hits = 0;
    foreach (logQ[j]) if (logQ[j] == 24'h555555) hits++;
    checkOutput("stall word count", 32'(hits), 1);
    checkOutput("stall log size", 32'(logQ.size()), 1);

    applyStimulus(17, 25);
    applyStimulus(26, 33);

    // all four requesting: rotation 0,1,2,3,0 with four words each
    resetPulse();
    k = '{0, 0, 0, 0};
    prevGnt = '0;
    cyc = 0;
    fifo_full = 1'b0;
    while (logQ.size() < 20 && cyc < 60) begin
      d0 = 24'hA00000 + 24'(k[0]); d1 = 24'hA00100 + 24'(k[1]);
      d2 = 24'hA00200 + 24'(k[2]); d3 = 24'hA00300 + 24'(k[3]);
      req = 4'b1111;
      #2;
      if (gnt != 4'b0000 && gnt != prevGnt) gseq.push_back(gnt);
      prevGnt = gnt;
      for (int i = 0; i < 4; i++) if (ack[i]) k[i]++;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("rr log size", 32'(logQ.size()), 20);
    for (int j = 0; j < 20 && j < logQ.size(); j++)
      checkOutput($sformatf("rr log%0d", j), 32'(logQ[j]),
                  32'h00A00000 + 32'((j / 4) % 4) * 32'h100 + 32'((j / 16) * 4 + j % 4));
    checkOutput("rr gnt count", 32'(gseq.size() >= 5), 1);
    for (int j = 0; j < 5 && j < gseq.size(); j++)
      checkOutput($sformatf("rr gnt%0d", j), 32'(gseq[j]), 32'(4'b0001 << (j % 4)));

    // async reset mid-burst after ptr has moved to 2
    resetPulse();
    req = 4'b0010; d1 = 24'h101; d3 = 24'h777; d0 = 24'h0a0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 4'b1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    checkOutput("pre-reset gnt", 32'(gnt), 32'h8);
    checkOutput("pre-reset wr", 32'(fifo_wr), 1);
    rst = 1'b1;
    #1;
    checkOutput("async gnt", 32'(gnt), 0);
    checkOutput("async wr", 32'(fifo_wr), 0);
    checkOutput("async ack", 32'(ack), 0);
    checkOutput("async din", 32'(fifo_din), 0);
    @(posedge clk); #3;
    rst = 1'b0;
    req = 4'b1001;
    @(posedge clk); #1;
    checkOutput("post-reset gnt", 32'(gnt), 32'h1);
    checkOutput("post-reset wr", 32'(fifo_wr), 1);
    checkOutput("post-reset din", 32'(fifo_din), 32'h0a0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one `fifo` write port among N producers. Each producer presents a word and a request; the arbiter grants one producer at a time for a bounded burst. It drives the FIFO `wr`/`din` pins and gates writes with the FIFO `full` flag, so no word is lost or duplicated. It sits between the producer blocks and the `fifo` instance, using the same `WIDTH` as the FIFO.

## Interface
Parameters:
- `WIDTH`, 24, data word width; must match the FIFO `WIDTH`.
- `N`, 4, number of requesters (2..8).
- `BURST`, 4, maximum words accepted per grant (1..15).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  N  `req[i]` high means producer i has a valid word on its slice of `din`.
- `din`  in  N*WIDTH  producer data; producer i uses bits `[i*WIDTH +: WIDTH]`.
- `ack`  out  N  `ack[i]` high means producer i's word is written to the FIFO at this edge; the producer advances its data.
- `gnt`  out  N  registered one-hot of the current burst owner; all zero when idle.
- `fifo_wr`  out  1  to FIFO `wr`.
- `fifo_din`  out  WIDTH  to FIFO `din`.
- `fifo_full`  in  1  from FIFO `full`.

## Operation
- State machine with two states: IDLE and BURST. Registers: `state`, `gnt`, `ptr` (round-robin start index, 0..N-1), `cnt` (words accepted in the current burst).
- **IDLE**
  - `fifo_wr`=0 and `ack`=0.
  - If `req`≠0, pick the first i with `req[i]`=1, searching `ptr`, `ptr`+1, … modulo N.
  - At the edge: `gnt`<=onehot(i), `cnt`<=0, state<=BURST.
  - If `req`=0, stay in IDLE.
- **BURST** (owner o = index of the set bit in `gnt`)
  - `fifo_din` = `din` slice o, combinational mux.
  - `fifo_wr` = `req[o]` & ~`fifo_full`, combinational.
  - `ack[o]` = `fifo_wr`; all other `ack` bits are 0.
  - On an accepted word (`fifo_wr`=1), `cnt`<=`cnt`+1.
  - Exit to IDLE at the edge when either:
    - the word is accepted and `cnt`==BURST-1, or
    - `req[o]`=0.
  - On exit: `gnt`<=0 and `ptr`<=(o+1) mod N.
  - `req[o]`=1 with `fifo_full`=1: stall in BURST indefinitely. No write, no ack, `cnt` holds.
- In IDLE, `fifo_din` holds its last value; its value is don't-care whenever `fifo_wr`=0.
- Requests from non-owners are ignored until the next arbitration. A producer must keep `req` and its data stable until it sees `ack`.
- Fairness: at most BURST words per grant, then the pointer moves past the owner. Any continuously requesting producer is served within N-1 other bursts.
- The arbiter never writes while `fifo_full`=1. This is conservative: it does not use the FIFO's simultaneous read/write-on-full capability.

## Timing
- Reset values (immediate on `rst` rising, independent of `clk`): state IDLE, `gnt`=0, `ptr`=0, `cnt`=0.
  - Outputs during reset: `ack`=0, `fifo_wr`=0, `fifo_din`=0.
- Reset asserted mid-burst: the burst aborts and no further `fifo_wr` is issued. A word already written at an earlier edge remains in the FIFO.
- Latency: `req` sampled high at edge k → `gnt` set after edge k → first `fifo_wr` in cycle k+1, written at edge k+1.
- Back-to-back words within a burst: one per cycle while `req[o]`=1 and not full.
- Exactly one IDLE (arbitration) cycle separates consecutive bursts. Sustained throughput is therefore BURST/(BURST+1).
- `fifo_full` rising in the same cycle as a pending word: that word is not written and `ack` stays low. The write resumes in the first cycle with `fifo_full`=0.
- `req[o]` dropping: takes effect in the same cycle (no write). IDLE follows at the next edge.

## Test plan
- Single producer: `req[2]` held high with data 0x000010..0x000015, BURST=4, FIFO empty.
  - Expect writes of 0x10..0x13 on 4 consecutive cycles.
  - Then 1 IDLE cycle, re-grant to 2, then writes of 0x14 and 0x15.
  - `ack[2]` pulses exactly 6 times.
- All four requesting continuously, producer i data = 0xA00000+i·0x100+k.
  - FIFO order: 4 words from producer 0, then 1, then 2, then 3, then 0 again.
  - `gnt` sequence 0001, 0010, 0100, 1000.
- Full stall: fill the FIFO with 16 words, keep `req[1]` high with 0x555555.
  - Expect no `fifo_wr` and no ack.
  - After one FIFO read, 0x555555 is written in the first cycle with `fifo_full`=0.
  - Verify no word is lost or duplicated when draining all 16.
- Owner drops `req` after 2 words: burst ends.
  - `ptr` advances, so a pending `req[3]` is granted next even though `req[1]` re-asserts.
- Async reset asserted mid-burst between clock edges.
  - `gnt`, `fifo_wr` and `ack` go to 0 immediately.
  - After release, arbitration restarts from producer 0.
- Pointer wrap: only `req[3]` then `req[0]` pending, `ptr`=3.
  - Expect 3 served first, then `ptr` wraps to 0 and 0 is granted.
